// File: rtl/row_router_ctrl_pkg.sv
// Shared types and width helpers for the row router sequencer.
package router_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SWEEP,
      FLUSH,
      DRAIN,
      DONE
   } state_t;

   // Counter widths never collapse to zero bits, so single-entry configurations still elaborate.
   function automatic int unsigned row_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned sweep_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/row_router_ctrl_spad_sweep_counter.sv
// Scratchpad sweep address counter plus the read-valid delay pipe that times comparator enable.
module spad_sweep_counter #(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned SPAD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clear,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] i_load_addr,
   input  logic                  i_inc,
   input  logic [ADDR_WIDTH-1:0] i_end_addr,
   input  logic                  i_read_en,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last,
   output logic                  o_ac_en
);

   logic [ADDR_WIDTH-1:0]   addr;
   logic [SPAD_LATENCY-1:0] pipe;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr <= '0;
      end else if (i_clear) begin
         addr <= '0;
      end else if (i_load) begin
         addr <= i_load_addr;
      end else if (i_inc) begin
         addr <= addr + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pipe <= '0;
      end else if (i_clear) begin
         pipe <= '0;
      end else begin
         pipe[0] <= i_read_en;
         for (int unsigned i = 1; i < SPAD_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign o_addr  = addr;
   assign o_last  = (addr == i_end_addr);
   assign o_ac_en = pipe[SPAD_LATENCY-1];

endmodule

// File: rtl/row_router_ctrl.sv
// Sequencer for a bank of row routers: load MPP FIFOs, sweep scratchpad, drain MISO FIFOs, clear.
// Define ROUTER_CTRL_PERF_EN to add the o_perf_sweeps / o_perf_stall counters.
module row_router_ctrl
   import router_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ROWS     = 3,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned SPAD_LATENCY = 1,
   parameter int unsigned MAX_SWEEPS   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_reg_clear,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_addr_start,
   input  logic [ADDR_WIDTH-1:0] i_addr_end,
   input  logic                  i_ag_valid,
   input  logic [NUM_ROWS-1:0]   i_mpp_empty,
   input  logic [NUM_ROWS-1:0]   i_miso_empty,
   input  logic                  i_pe_ready,
   output logic [NUM_ROWS-1:0]   o_mpp_write_en,
   output logic                  o_spad_read_en,
   output logic [ADDR_WIDTH-1:0] o_spad_addr,
   output logic                  o_ac_en,
   output logic                  o_miso_pop_en,
   output logic                  o_route_clear,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
`ifdef ROUTER_CTRL_PERF_EN
   ,
   output logic [7:0]            o_perf_sweeps,
   output logic [15:0]           o_perf_stall
`endif
);

   localparam int unsigned ROW_W   = row_idx_w(NUM_ROWS);
   localparam int unsigned SWEEP_W = sweep_w(MAX_SWEEPS);
   localparam int unsigned FL_W    = row_idx_w(SPAD_LATENCY);

   state_t                state, state_n;
   logic [ROW_W-1:0]      row;
   logic [SWEEP_W-1:0]    sweep;
   logic [FL_W-1:0]       flush_cnt;
   logic [ADDR_WIDTH-1:0] start_q, end_q;
   logic                  err_q;

   logic                  accept, row_inc, sweep_inc, err_set, flush_done;
   logic                  addr_load, addr_inc, read_en, pop;
   logic                  row_last, sweep_last, flush_last, addr_last;
   logic [NUM_ROWS-1:0]   mpp_we;
   logic [ADDR_WIDTH-1:0] addr;

   assign row_last   = (row == ROW_W'(NUM_ROWS - 1));
   assign sweep_last = (sweep == SWEEP_W'(MAX_SWEEPS - 1));
   assign flush_last = (flush_cnt == FL_W'(SPAD_LATENCY - 1));

   spad_sweep_counter #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SPAD_LATENCY(SPAD_LATENCY)
   ) u_sweep (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clear    (i_reg_clear),
      .i_load     (addr_load),
      .i_load_addr(start_q),
      .i_inc      (addr_inc),
      .i_end_addr (end_q),
      .i_read_en  (read_en),
      .o_addr     (addr),
      .o_last     (addr_last),
      .o_ac_en    (o_ac_en)
   );

   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      row_inc    = 1'b0;
      sweep_inc  = 1'b0;
      err_set    = 1'b0;
      flush_done = 1'b0;
      addr_load  = 1'b0;
      addr_inc   = 1'b0;
      read_en    = 1'b0;
      pop        = 1'b0;
      mpp_we     = '0;
      case (state)
         IDLE: begin
            if (i_start) begin
               accept  = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: begin
            if (i_ag_valid) begin
               row_inc = 1'b1;
               for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                  mpp_we[r] = (row == ROW_W'(r));
               end
               if (row_last) begin
                  addr_load = 1'b1;
                  state_n   = SWEEP;
               end
            end
         end
         SWEEP: begin
            read_en  = 1'b1;
            addr_inc = 1'b1;
            if (addr_last) state_n = FLUSH;
         end
         FLUSH: begin
            // Decide only after the last read's comparator window has passed.
            if (flush_last) begin
               flush_done = 1'b1;
               if (&i_mpp_empty) begin
                  state_n = DRAIN;
               end else if (sweep_last) begin
                  err_set = 1'b1;
                  state_n = DONE;
               end else begin
                  sweep_inc = 1'b1;
                  addr_load = 1'b1;
                  state_n   = SWEEP;
               end
            end
         end
         DRAIN: begin
            if (&i_miso_empty) begin
               state_n = DONE;
            end else if (|i_miso_empty) begin
               err_set = 1'b1;
               state_n = DONE;
            end else begin
               pop = i_pe_ready;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         row       <= '0;
         sweep     <= '0;
         flush_cnt <= '0;
         start_q   <= '0;
         end_q     <= '0;
         err_q     <= 1'b0;
      end else if (i_reg_clear) begin
         state     <= IDLE;
         row       <= '0;
         sweep     <= '0;
         flush_cnt <= '0;
         start_q   <= '0;
         end_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            start_q <= i_addr_start;
            end_q   <= i_addr_end;
            row     <= '0;
            sweep   <= '0;
            err_q   <= 1'b0;
         end
         if (row_inc)   row   <= row_last ? '0 : row + ROW_W'(1);
         if (sweep_inc) sweep <= sweep + SWEEP_W'(1);
         if (err_set)   err_q <= 1'b1;
         if ((state == FLUSH) && !flush_last) flush_cnt <= flush_cnt + FL_W'(1);
         else                                 flush_cnt <= '0;
      end
   end

`ifdef ROUTER_CTRL_PERF_EN
   logic [7:0]  perf_sweeps;
   logic [15:0] perf_stall;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         perf_sweeps <= '0;
         perf_stall  <= '0;
      end else if (i_reg_clear || accept) begin
         perf_sweeps <= '0;
         perf_stall  <= '0;
      end else begin
         if (flush_done && (perf_sweeps != '1)) perf_sweeps <= perf_sweeps + 8'd1;
         if ((state == DRAIN) && !i_pe_ready && (perf_stall != '1))
            perf_stall <= perf_stall + 16'd1;
      end
   end

   assign o_perf_sweeps = perf_sweeps;
   assign o_perf_stall  = perf_stall;
`endif

   assign o_mpp_write_en = mpp_we;
   assign o_spad_read_en = read_en;
   assign o_spad_addr    = read_en ? addr : '0;
   assign o_miso_pop_en  = pop;
   assign o_route_clear  = (state == DONE);
   assign o_done         = (state == DONE);
   assign o_busy         = (state != IDLE);
   assign o_error        = err_q;

endmodule

// File: tb/tb_row_router_ctrl.sv
// Directed table-driven bench for row_router_ctrl at default parameters.
module tb_row_router_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst, i_reg_clear, i_start, i_ag_valid, i_pe_ready;
   logic [7:0] i_addr_start, i_addr_end;
   logic [2:0] i_mpp_empty, i_miso_empty;
   logic [2:0] o_mpp_write_en;
   logic       o_spad_read_en, o_ac_en, o_miso_pop_en, o_route_clear, o_busy, o_done, o_error;
   logic [7:0] o_spad_addr;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 i_clk = ~i_clk;

   row_router_ctrl #(
      .NUM_ROWS    (3),
      .ADDR_WIDTH  (8),
      .SPAD_LATENCY(1),
      .MAX_SWEEPS  (4)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_reg_clear   (i_reg_clear),
      .i_start       (i_start),
      .i_addr_start  (i_addr_start),
      .i_addr_end    (i_addr_end),
      .i_ag_valid    (i_ag_valid),
      .i_mpp_empty   (i_mpp_empty),
      .i_miso_empty  (i_miso_empty),
      .i_pe_ready    (i_pe_ready),
      .o_mpp_write_en(o_mpp_write_en),
      .o_spad_read_en(o_spad_read_en),
      .o_spad_addr   (o_spad_addr),
      .o_ac_en       (o_ac_en),
      .o_miso_pop_en (o_miso_pop_en),
      .o_route_clear (o_route_clear),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_error       (o_error)
   );

   typedef struct {
      logic       clr, st, agv;
      logic [2:0] mpp_e, miso_e;
      logic       rdy;
      logic [2:0] we;
      logic       rd;
      logic [7:0] addr;
      logic       ac, pop, busy, done, err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic clr, st, agv, input logic [2:0] mpp_e, miso_e,
                               input logic rdy, input logic [2:0] we, input logic rd,
                               input logic [7:0] addr, input logic ac, pop, busy, done, err);
      vec_t v;
      v.clr = clr; v.st = st; v.agv = agv; v.mpp_e = mpp_e; v.miso_e = miso_e; v.rdy = rdy;
      v.we = we; v.rd = rd; v.addr = addr; v.ac = ac; v.pop = pop;
      v.busy = busy; v.done = done; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      string p;
      @(negedge i_clk);
      i_reg_clear = v.clr; i_start = v.st; i_ag_valid = v.agv;
      i_mpp_empty = v.mpp_e; i_miso_empty = v.miso_e; i_pe_ready = v.rdy;
      #1;
      p = $sformatf("%s[%0d]", tag, idx);
      chk({p, " write_en"}, 16'(o_mpp_write_en), 16'(v.we));
      chk({p, " read_en"},  16'(o_spad_read_en), 16'(v.rd));
      chk({p, " addr"},     16'(o_spad_addr),    16'(v.addr));
      chk({p, " ac_en"},    16'(o_ac_en),        16'(v.ac));
      chk({p, " pop"},      16'(o_miso_pop_en),  16'(v.pop));
      chk({p, " busy"},     16'(o_busy),         16'(v.busy));
      chk({p, " done"},     16'(o_done),         16'(v.done));
      chk({p, " clear"},    16'(o_route_clear),  16'(v.done));
      chk({p, " error"},    16'(o_error),        16'(v.err));
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[i]) apply(tbl[i], tag, i);
      tbl.delete();
   endtask

   // Row builders: each pushes the inputs of one cycle and the outputs expected in that cycle.
   task automatic idle_start(input logic err);
      tbl.push_back(mk(0, 1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 8'd0, 0, 0, 0, 0, err));
   endtask

   task automatic load_rows(input logic st_mid);
      tbl.push_back(mk(0, 0,      1, 3'b000, 3'b000, 1, 3'b001, 0, 8'd0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, st_mid, 1, 3'b000, 3'b000, 1, 3'b010, 0, 8'd0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0,      1, 3'b000, 3'b000, 1, 3'b100, 0, 8'd0, 0, 0, 1, 0, 0));
   endtask

   task automatic sweep_rows(input int lo, input int hi);
      for (int a = lo; a <= hi; a++)
         tbl.push_back(mk(0, 0, 1, 3'b000, 3'b000, 1, 3'b000, 1, 8'(a), (a != lo), 0, 1, 0, 0));
   endtask

   task automatic flush_row(input logic [2:0] mpp_e);
      tbl.push_back(mk(0, 0, 1, mpp_e, 3'b000, 1, 3'b000, 0, 8'd0, 1, 0, 1, 0, 0));
   endtask

   task automatic drain_row(input logic [2:0] miso_e, input logic rdy, input logic pop);
      tbl.push_back(mk(0, 0, 0, 3'b111, miso_e, rdy, 3'b000, 0, 8'd0, 0, pop, 1, 0, 0));
   endtask

   task automatic done_row(input logic err);
      tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 1, 3'b000, 0, 8'd0, 0, 0, 1, 1, err));
   endtask

   task automatic idle_row(input logic err);
      tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 1, 3'b000, 0, 8'd0, 0, 0, 0, 0, err));
   endtask

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks + 1);
      $finish;
   end

   initial begin
      int reads, pops, first_a, last_a, done_seen, err_at_done;

      i_rst = 1'b1; i_reg_clear = 1'b0; i_start = 1'b0; i_ag_valid = 1'b0; i_pe_ready = 1'b0;
      i_addr_start = 8'd0; i_addr_end = 8'd0; i_mpp_empty = 3'b000; i_miso_empty = 3'b000;
      repeat (2) @(negedge i_clk);
      #1;
      chk("reset busy", 16'(o_busy), 16'd0);
      chk("reset read_en", 16'(o_spad_read_en), 16'd0);
      chk("reset error", 16'(o_error), 16'd0);
      chk("reset write_en", 16'(o_mpp_write_en), 16'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Normal job 0..7, with a start pulse during LOAD that must be ignored.
      i_addr_start = 8'd0; i_addr_end = 8'd7;
      idle_start(0); load_rows(1); sweep_rows(0, 7); flush_row(3'b111);
      for (int k = 0; k < 4; k++) drain_row(3'b000, 1, 1);
      drain_row(3'b111, 1, 0); done_row(0); idle_row(0);
      run_table("normal");

      // Three sweeps, then backpressured drain ending in a row mismatch.
      idle_start(0); load_rows(0);
      sweep_rows(0, 7); flush_row(3'b110);
      sweep_rows(0, 7); flush_row(3'b110);
      sweep_rows(0, 7); flush_row(3'b111);
      drain_row(3'b000, 1, 1); drain_row(3'b000, 0, 0);
      drain_row(3'b000, 1, 1); drain_row(3'b000, 0, 0);
      drain_row(3'b010, 1, 0); done_row(1); idle_row(1);
      run_table("multi");

      // Sweep exhaustion over 2..4; error from the previous job is held until start is accepted.
      i_addr_start = 8'd2; i_addr_end = 8'd4;
      idle_start(1); load_rows(0);
      for (int s = 0; s < 4; s++) begin
         sweep_rows(2, 4); flush_row(3'b011);
      end
      done_row(1); idle_row(1);
      run_table("exhaust");

      // Single-address sweep.
      i_addr_start = 8'd3; i_addr_end = 8'd3;
      idle_start(1); load_rows(0); sweep_rows(3, 3); flush_row(3'b111);
      drain_row(3'b111, 1, 0); done_row(0); idle_row(0);
      run_table("single");

      // Synchronous clear during DRAIN: back to IDLE with no done pulse.
      i_addr_start = 8'd0; i_addr_end = 8'd0;
      idle_start(0); load_rows(0); sweep_rows(0, 0); flush_row(3'b111);
      drain_row(3'b000, 1, 1);
      tbl.push_back(mk(1, 0, 0, 3'b111, 3'b111, 1, 3'b000, 0, 8'd0, 0, 0, 1, 0, 0));
      idle_row(0); idle_row(0);
      run_table("clear");

      // Free-running job over 1..6 with three MISO entries, bounded by a cycle budget.
      i_addr_start = 8'd1; i_addr_end = 8'd6;
      reads = 0; pops = 0; first_a = -1; last_a = -1; done_seen = 0; err_at_done = 0;
      for (int cyc = 0; cyc < 60 && done_seen == 0; cyc++) begin
         @(negedge i_clk);
         i_start = (cyc == 0); i_ag_valid = 1'b1; i_mpp_empty = 3'b111; i_pe_ready = 1'b1;
         i_miso_empty = (pops >= 3) ? 3'b111 : 3'b000;
         #1;
         if (o_spad_read_en) begin
            if (first_a < 0) first_a = int'(o_spad_addr);
            last_a = int'(o_spad_addr);
            reads++;
         end
         if (o_miso_pop_en) pops++;
         if (o_done) begin
            done_seen = 1;
            err_at_done = int'(o_error);
         end
      end
      i_start = 1'b0;
      chk("count done seen", 16'(done_seen), 16'd1);
      chk("count reads", 16'(reads), 16'd6);
      chk("count first addr", 16'(first_a), 16'd1);
      chk("count last addr", 16'(last_a), 16'd6);
      chk("count pops", 16'(pops), 16'd3);
      chk("count error", 16'(err_at_done), 16'd0);

      // Asynchronous reset while the sweep is at address 5.
      i_addr_start = 8'd0; i_addr_end = 8'd7;
      idle_start(0); load_rows(0); sweep_rows(0, 4);
      run_table("rstsweep");
      @(negedge i_clk);
      i_start = 1'b0; i_ag_valid = 1'b1; i_mpp_empty = 3'b000; i_miso_empty = 3'b000;
      #1;
      chk("pre-reset read_en", 16'(o_spad_read_en), 16'd1);
      chk("pre-reset addr", 16'(o_spad_addr), 16'd5);
      chk("pre-reset ac_en", 16'(o_ac_en), 16'd1);
      #2 i_rst = 1'b1;
      #1;
      chk("async reset read_en", 16'(o_spad_read_en), 16'd0);
      chk("async reset addr", 16'(o_spad_addr), 16'd0);
      chk("async reset busy", 16'(o_busy), 16'd0);
      chk("async reset ac_en", 16'(o_ac_en), 16'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("post-reset ac_en", 16'(o_ac_en), 16'd0);
      chk("post-reset busy", 16'(o_busy), 16'd0);
      @(negedge i_clk);
      #1;
      chk("post-reset idle ac_en", 16'(o_ac_en), 16'd0);
      chk("post-reset idle read_en", 16'(o_spad_read_en), 16'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/row_router_ctrl.md
Name: row_router_ctrl

Overview:
- Sequencer for a bank of NUM_ROWS row routers.
- Loads each row's MPP FIFO from the shared address generator, one row at a time.
- Sweeps the scratchpad address range and enables address comparison while any row still has pending addresses.
- Drains all MISO FIFOs in lockstep to the PE array, then clears the routers for the next tile.

Parameters:
- NUM_ROWS, 3, number of row routers controlled
- ADDR_WIDTH, 8, scratchpad address width
- SPAD_LATENCY, 1, cycles from read enable to valid scratchpad data (≥1)
- MAX_SWEEPS, 4, maximum full-range sweeps before error

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_reg_clear  in  1  synchronous clear to IDLE
- i_start  in  1  start pulse; honoured only in IDLE
- i_addr_start  in  ADDR_WIDTH  first scratchpad address of sweep
- i_addr_end  in  ADDR_WIDTH  last scratchpad address of sweep (≥ start)
- i_ag_valid  in  1  address generator has a row vector ready
- i_mpp_empty  in  NUM_ROWS  per-row MPP FIFO empty
- i_miso_empty  in  NUM_ROWS  per-row MISO FIFO empty
- i_pe_ready  in  1  PE array accepts a column this cycle
- o_mpp_write_en  out  NUM_ROWS  one-hot MPP write strobe
- o_spad_read_en  out  1  scratchpad read request
- o_spad_addr  out  ADDR_WIDTH  scratchpad read address
- o_ac_en  out  1  comparator enable, aligned with returning data
- o_miso_pop_en  out  1  broadcast MISO pop
- o_route_clear  out  1  one-cycle router register clear
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  sticky error

Behaviour:
- Reset (i_rst, async): state IDLE; row/sweep counters 0; all outputs 0. i_reg_clear has the same effect synchronously and overrides all events in that cycle.
- Register updates occur on the rising edge; strobes are decoded combinationally from registered state.
- IDLE: on i_start, latch start/end, row=0, sweep=0, clear o_error, go LOAD. o_error persists in IDLE until the next accepted i_start.
- LOAD: o_mpp_write_en = onehot(row) when i_ag_valid, else 0. Each accepted cycle increments row. On accept with row==NUM_ROWS-1, go SWEEP with addr=start.
- SWEEP: o_spad_read_en=1, o_spad_addr=addr, addr increments each cycle. On the cycle addr==end (that read is still issued), go FLUSH.
- o_ac_en is o_spad_read_en delayed SPAD_LATENCY cycles through a shift pipe. The pipe runs in every state and is zeroed by reset/clear.
- FLUSH: no reads for SPAD_LATENCY cycles; in-flight o_ac_en still asserts. Then:
  - &i_mpp_empty → DRAIN.
  - else if sweep==MAX_SWEEPS-1 → set o_error, go DONE.
  - else sweep++, addr=start, go SWEEP.
- DRAIN: o_miso_pop_en = i_pe_ready & ~|i_miso_empty.
  - All rows empty → DONE.
  - Some but not all rows empty (row mismatch) → set o_error, go DONE, no pop that cycle.
- DONE: o_done=1 and o_route_clear=1 for exactly one cycle, then IDLE.
- start==end is a legal one-address sweep.
- i_start outside IDLE is ignored. i_ag_valid outside LOAD is ignored.

Optional Feature:
- Macro ROUTER_CTRL_PERF_EN.
- When defined, adds outputs:
  - o_perf_sweeps (8b): sweeps used in the last job.
  - o_perf_stall (16b): DRAIN cycles with i_pe_ready=0, saturating.
  - Both counters clear on i_start, reset and i_reg_clear.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package router_ctrl_pkg:
  - state enum {IDLE, LOAD, SWEEP, FLUSH, DRAIN, DONE}
  - ROW_IDX_W = $clog2(NUM_ROWS) helper
  - SWEEP_W = $clog2(MAX_SWEEPS)
- One sub-module, spad_sweep_counter: holds the address counter with load/increment/last flag, plus the SPAD_LATENCY valid-delay pipe for o_ac_en.

Test Plan:
- Reset mid-SWEEP (assert i_rst at addr 5) → outputs 0 immediately, state IDLE, o_ac_en pipe empty next cycle.
- Normal job: start=0, end=7, ag_valid held high, mpp_empty goes 3'b111 after the first sweep, miso 4 entries each, pe_ready=1 → write_en 001,010,100; reads 0..7; ac_en lags 1 cycle; 4 pops; o_done at end, o_error=0.
- Multi-sweep: mpp_empty stays 3'b110 until the 3rd FLUSH → addr wraps 7→0 twice; sweep counter 2; DRAIN entered.
- Sweep exhaustion: mpp_empty never all-ones, MAX_SWEEPS=4 → o_error=1 after the 4th FLUSH; o_done and o_route_clear pulse; no pops.
- DRAIN backpressure and mismatch:
  - pe_ready toggling 1010 → pops only on ready cycles.
  - miso_empty=3'b010 → no pop, o_error=1, DONE.
- Edge cases:
  - start==end==3 → exactly one read at 3.
  - i_start during LOAD ignored.
  - i_reg_clear during DRAIN → IDLE next cycle, o_done never pulses.
